// File: rtl/mc_issuer_pkg.sv
// Shared constants, opcode encodings and FSM state type for the DDR5 request issuer.
// Opcode bit 0 doubles as the controller's command-valid bit (word bit 28).
package mc_issuer_pkg;

  localparam int unsigned ADDR_WIDTH     = 28;
  localparam int unsigned CMD_WIDTH      = 32;
  localparam int unsigned CMD_OPCODE_MSB = 31;
  localparam int unsigned CMD_OPCODE_LSB = 28;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_READ    = 4'h1;
  localparam logic [3:0] OP_WRITE   = 4'h3;
  localparam logic [3:0] OP_REFRESH = 4'h5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } issuer_state_e;

  function automatic logic [CMD_WIDTH-1:0] make_cmd(input logic [3:0]            op,
                                                    input logic [ADDR_WIDTH-1:0] addr);
    logic [CMD_WIDTH-1:0] cmd;
    cmd                                = '0;
    cmd[CMD_OPCODE_MSB:CMD_OPCODE_LSB] = op;
    cmd[ADDR_WIDTH-1:0]                = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/mc_request_issuer_if.sv
// Host request handshake plus controller-facing command bus of the request issuer.
// master = the issuer itself, slave = host/controller side driving it.
interface mc_request_issuer_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  import mc_issuer_pkg::*;

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_WIDTH-1:0]         req_addr;
  logic                          memory_interface_ready;
  logic [CMD_WIDTH-1:0]          system_bus;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          refresh_overdue;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  memory_interface_ready,
    output req_ready,
    output system_bus,
    output fifo_count,
    output refresh_overdue
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_addr,
    output memory_interface_ready,
    input  req_ready,
    input  system_bus,
    input  fifo_count,
    input  refresh_overdue
  );

endinterface

// File: rtl/mc_req_fifo.sv
// In-order request FIFO with first-word-fallthrough read data and registered occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module mc_req_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 29
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mc_request_issuer.sv
// Buffers host requests, injects periodic refreshes and serialises them as one-cycle
// command words on the DDR5 controller's system_bus, with a forced gap between words.
module mc_request_issuer
  import mc_issuer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned REFRESH_INTERVAL = 3900,
  parameter int unsigned ISSUE_GAP        = 2
) (
  input logic                 clk,
  input logic                 reset,
  mc_request_issuer_if.master mc_if
);

  localparam int unsigned RefW = $clog2(REFRESH_INTERVAL);
  localparam int unsigned GapW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_INTERVAL - 1);
  // The IDLE decision cycle is itself a NOP cycle, so GAP lasts ISSUE_GAP-1 cycles.
  localparam logic [GapW-1:0] GapLoad = GapW'((ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0);

  issuer_state_e        state_q, state_d;
  logic [CMD_WIDTH-1:0] bus_q, bus_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [RefW-1:0]      ref_cnt_q, ref_cnt_d;
  logic                 pending_q, pending_d;
  logic                 overdue_q, overdue_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_head;
  logic                  ref_wrap, issue_refresh;

  assign fifo_push = mc_if.req_valid && !fifo_full;

  mc_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i ({mc_if.req_write, mc_if.req_addr}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (mc_if.fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mc_if.req_ready       = !fifo_full;
  assign mc_if.system_bus      = bus_q;
  assign mc_if.refresh_overdue = overdue_q;

  assign ref_wrap  = (ref_cnt_q == RefLast);
  assign ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RefW'(1);

  always_comb begin
    state_d       = state_q;
    bus_d         = bus_q;
    gap_d         = gap_q;
    fifo_pop      = 1'b0;
    issue_refresh = 1'b0;
    case (state_q)
      IDLE: begin
        if (mc_if.memory_interface_ready && (pending_q || !fifo_empty)) begin
          state_d = ISSUE;
          if (pending_q) begin
            issue_refresh = 1'b1;
            bus_d         = make_cmd(OP_REFRESH, '0);
          end else begin
            fifo_pop = 1'b1;
            bus_d    = make_cmd(fifo_head[ADDR_WIDTH] ? OP_WRITE : OP_READ,
                                fifo_head[ADDR_WIDTH-1:0]);
          end
        end
      end
      ISSUE: begin
        bus_d = make_cmd(OP_NOP, '0);
        if (ISSUE_GAP > 1) begin
          state_d = GAP;
          gap_d   = GapLoad;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new expiry re-arms the pending flag even if the old refresh is issued on the same edge.
  assign pending_d = ref_wrap || (pending_q && !issue_refresh);
  assign overdue_d = ref_wrap && pending_q && !issue_refresh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bus_q     <= '0;
      gap_q     <= '0;
      ref_cnt_q <= '0;
      pending_q <= 1'b0;
      overdue_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      gap_q     <= gap_d;
      ref_cnt_q <= ref_cnt_d;
      pending_q <= pending_d;
      overdue_q <= overdue_d;
    end
  end

endmodule

// File: tb/tb_mc_request_issuer.sv
// Directed bench for mc_request_issuer: dut_a uses the default refresh interval,
// dut_b a short interval of 16 for the refresh scenarios.
module tb_mc_request_issuer;
  import mc_issuer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mc_request_issuer_if #(.FIFO_DEPTH(8)) ifa ();
  mc_request_issuer_if #(.FIFO_DEPTH(8)) ifb ();

  mc_request_issuer #(
    .FIFO_DEPTH       (8),
    .REFRESH_INTERVAL (3900),
    .ISSUE_GAP        (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .mc_if (ifa.master)
  );

  mc_request_issuer #(
    .FIFO_DEPTH       (8),
    .REFRESH_INTERVAL (16),
    .ISSUE_GAP        (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .mc_if (ifb.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset                      = 1'b1;
    ifa.req_valid              = 1'b0;
    ifa.req_write              = 1'b0;
    ifa.req_addr               = '0;
    ifa.memory_interface_ready = 1'b0;
    ifb.req_valid              = 1'b0;
    ifb.req_write              = 1'b0;
    ifb.req_addr               = '0;
    ifb.memory_interface_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (ifa.system_bus !== 32'h0) begin
      n_miss++; $display("FAIL reset_bus: got %h want %h", ifa.system_bus, 32'h0);
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd0) begin
      n_miss++; $display("FAIL reset_count: got %0d want 0", ifa.fifo_count);
    end
    n_vec++;
    if (ifa.req_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_ready: got %b want 1", ifa.req_ready);
    end
    n_vec++;
    if (ifb.refresh_overdue !== 1'b0) begin
      n_miss++; $display("FAIL reset_overdue: got %b want 0", ifb.refresh_overdue);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    ifa.memory_interface_ready = 1'b1;
    ifa.req_write              = 1'b0;
    ifa.req_addr               = 28'h0000ABC;
    ifa.req_valid              = 1'b1;
    step();
    ifa.req_valid = 1'b0;
    n_vec++;
    if (ifa.system_bus !== 32'h0) begin
      n_miss++; $display("FAIL single_early: got %h want %h", ifa.system_bus, 32'h0);
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd1) begin
      n_miss++; $display("FAIL single_count1: got %0d want 1", ifa.fifo_count);
    end
    step();
    n_vec++;
    if (ifa.system_bus !== 32'h10000ABC) begin
      n_miss++; $display("FAIL single_word: got %h want %h", ifa.system_bus, 32'h10000ABC);
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd0) begin
      n_miss++; $display("FAIL single_count0: got %0d want 0", ifa.fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (ifa.system_bus !== 32'h0) begin
        n_miss++; $display("FAIL single_gap%0d: got %h want %h", i, ifa.system_bus, 32'h0);
      end
    end
  endtask

  task automatic test_fill();
    int          n;
    int          last;
    logic [31:0] exp_w;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ifa.req_valid = 1'b1;
      ifa.req_write = 1'b1;
      ifa.req_addr  = 28'h0200000 + 28'(i);
      step();
    end
    n_vec++;
    if (ifa.req_ready !== 1'b0) begin
      n_miss++; $display("FAIL fill_ready: got %b want 0", ifa.req_ready);
    end
    ifa.req_addr = 28'h0FFFFFF;
    step();
    ifa.req_valid = 1'b0;
    n_vec++;
    if (ifa.fifo_count !== 4'd8) begin
      n_miss++; $display("FAIL fill_count: got %0d want 8", ifa.fifo_count);
    end
    ifa.memory_interface_ready = 1'b1;
    n    = 0;
    last = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ifa.system_bus !== 32'h0) begin
        exp_w = {OP_WRITE, 28'h0200000 + 28'(n)};
        n_vec++;
        if (n >= 8 || ifa.system_bus !== exp_w) begin
          n_miss++; $display("FAIL fill_word%0d: got %h want %h", n, ifa.system_bus, exp_w);
        end
        if (n > 0) begin
          n_vec++;
          if (c - last != 3) begin
            n_miss++; $display("FAIL fill_spacing%0d: got %0d want 3", n, c - last);
          end
        end
        last = c;
        n++;
      end
    end
    n_vec++;
    if (n != 8) begin
      n_miss++; $display("FAIL fill_nwords: got %0d want 8", n);
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd0) begin
      n_miss++; $display("FAIL fill_drained: got %0d want 0", ifa.fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic [27:0] next_addr;
    logic        wr;
    int          pushed;
    do_reset();
    next_addr = 28'h0300000;
    pushed    = 0;
    for (int i = 0; i < 4; i++) begin
      ifa.req_valid = 1'b1;
      ifa.req_write = 1'b0;
      ifa.req_addr  = next_addr;
      q.push_back({OP_READ, next_addr});
      next_addr++;
      pushed++;
      step();
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd4) begin
      n_miss++; $display("FAIL b2b_count_pre: got %0d want 4", ifa.fifo_count);
    end
    ifa.memory_interface_ready = 1'b1;
    ifa.req_addr               = next_addr;
    q.push_back({OP_READ, next_addr});
    next_addr++;
    pushed++;
    step();
    n_vec++;
    if (ifa.fifo_count !== 4'd4) begin
      n_miss++; $display("FAIL b2b_count_simul: got %0d want 4", ifa.fifo_count);
    end
    exp_w = q.pop_front();
    n_vec++;
    if (ifa.system_bus !== exp_w) begin
      n_miss++; $display("FAIL b2b_first: got %h want %h", ifa.system_bus, exp_w);
    end
    // Stream until 20 requests have gone in, forcing several pointer wraps and full stalls.
    for (int c = 0; c < 300 && (pushed < 20 || q.size() > 0); c++) begin
      if (pushed < 20) begin
        wr            = next_addr[0];
        ifa.req_valid = 1'b1;
        ifa.req_write = wr;
        ifa.req_addr  = next_addr;
        if (ifa.req_ready === 1'b1) begin
          q.push_back({wr ? OP_WRITE : OP_READ, next_addr});
          next_addr++;
          pushed++;
        end
      end else begin
        ifa.req_valid = 1'b0;
      end
      step();
      if (ifa.system_bus !== 32'h0) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        n_vec++;
        if (ifa.system_bus !== exp_w) begin
          n_miss++; $display("FAIL b2b_order: got %h want %h", ifa.system_bus, exp_w);
        end
      end
    end
    ifa.req_valid = 1'b0;
    n_vec++;
    if (pushed != 20 || q.size() != 0) begin
      n_miss++; $display("FAIL b2b_drain: got pushed=%0d left=%0d want 20/0", pushed, q.size());
    end
  endtask

  task automatic test_refresh_priority();
    logic [31:0] exp_w [4];
    int          n;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ifb.req_valid = 1'b1;
      ifb.req_write = 1'b0;
      ifb.req_addr  = 28'h0400000 + 28'(i);
      step();
    end
    ifb.req_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    exp_w[0] = 32'h50000000;
    exp_w[1] = 32'h10400000;
    exp_w[2] = 32'h10400001;
    exp_w[3] = 32'h10400002;
    ifb.memory_interface_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      step();
      if (ifb.system_bus !== 32'h0) begin
        n_vec++;
        if (ifb.system_bus !== exp_w[n]) begin
          n_miss++; $display("FAIL refprio_word%0d: got %h want %h", n, ifb.system_bus, exp_w[n]);
        end
        n++;
      end
    end
    n_vec++;
    if (n != 4) begin
      n_miss++; $display("FAIL refprio_nwords: got %0d want 4", n);
    end
  endtask

  task automatic test_overdue();
    logic exp_o;
    int   refs;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      step();
      exp_o = (k == 32) || (k == 48);
      n_vec++;
      if (ifb.refresh_overdue !== exp_o) begin
        n_miss++; $display("FAIL overdue_k%0d: got %b want %b", k, ifb.refresh_overdue, exp_o);
      end
    end
    ifb.memory_interface_ready = 1'b1;
    refs = 0;
    for (int k = 51; k <= 62; k++) begin
      step();
      if (k == 51) begin
        n_vec++;
        if (ifb.system_bus !== 32'h50000000) begin
          n_miss++; $display("FAIL overdue_first: got %h want %h", ifb.system_bus, 32'h50000000);
        end
      end
      if (ifb.system_bus === 32'h50000000) refs++;
    end
    n_vec++;
    if (refs != 1) begin
      n_miss++; $display("FAIL overdue_nref: got %0d want 1", refs);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ifa.req_valid = 1'b1;
      ifa.req_write = 1'b1;
      ifa.req_addr  = 28'h0500000 + 28'(i);
      step();
    end
    ifa.req_valid              = 1'b0;
    ifa.memory_interface_ready = 1'b1;
    step();
    n_vec++;
    if (ifa.system_bus !== 32'h30500000 || ifa.fifo_count !== 4'd5) begin
      n_miss++;
      $display("FAIL rstmid_issue: got %h/%0d want %h/5", ifa.system_bus, ifa.fifo_count,
               32'h30500000);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (ifa.system_bus !== 32'h0) begin
      n_miss++; $display("FAIL rstmid_bus: got %h want %h", ifa.system_bus, 32'h0);
    end
    n_vec++;
    if (ifa.fifo_count !== 4'd0) begin
      n_miss++; $display("FAIL rstmid_count: got %0d want 0", ifa.fifo_count);
    end
    n_vec++;
    if (ifa.req_ready !== 1'b1) begin
      n_miss++; $display("FAIL rstmid_ready: got %b want 1", ifa.req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (ifa.system_bus !== 32'h0) begin
        n_miss++; $display("FAIL rstmid_quiet%0d: got %h want %h", i, ifa.system_bus, 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fill();
    test_back_to_back();
    test_refresh_priority();
    test_overdue();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
